// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register file: one read-only ID word at index 0 followed by NUM_RW_REGS
// read/write words. Write and read channels run independently, one transaction each.
module axi4_lite_reg_slave #(
   parameter int unsigned ADDR_BIT_WIDTH = 32,
   parameter int unsigned DATA_BIT_WIDTH = 32,
   parameter int unsigned NUM_RW_REGS    = 4,
   parameter logic [31:0] ID_VALUE       = 32'hC0DE_0001,
   parameter logic [31:0] RW_RESET_VALUE = 32'h0000_0000
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [ADDR_BIT_WIDTH-1:0]   i_awaddr,
   input  logic                        i_awvalid,
   output logic                        o_awready,
   input  logic [DATA_BIT_WIDTH-1:0]   i_wdata,
   input  logic [DATA_BIT_WIDTH/8-1:0] i_wstrb,
   input  logic                        i_wvalid,
   output logic                        o_wready,
   output logic [1:0]                  o_bresp,
   output logic                        o_bvalid,
   input  logic                        i_bready,
   input  logic [ADDR_BIT_WIDTH-1:0]   i_araddr,
   input  logic                        i_arvalid,
   output logic                        o_arready,
   output logic [DATA_BIT_WIDTH-1:0]   o_rdata,
   output logic [1:0]                  o_rresp,
   output logic                        o_rvalid,
   input  logic                        i_rready,
   output logic [32*NUM_RW_REGS-1:0]   o_rw_regs
);

   localparam int unsigned IdxW  = ADDR_BIT_WIDTH - 2;
   localparam int unsigned StrbW = DATA_BIT_WIDTH / 8;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;

   if (DATA_BIT_WIDTH != 32) begin : g_bad_data_width
      $error("axi4_lite_reg_slave: DATA_BIT_WIDTH must be 32");
   end
   if (NUM_RW_REGS < 1 || NUM_RW_REGS > 64) begin : g_bad_num_regs
      $error("axi4_lite_reg_slave: NUM_RW_REGS must be within 1..64");
   end
   if (ADDR_BIT_WIDTH < 2 + $clog2(NUM_RW_REGS + 1)) begin : g_bad_addr_width
      $error("axi4_lite_reg_slave: ADDR_BIT_WIDTH too small for the register map");
   end

   typedef enum logic {WCollect, WResp} wstate_e;
   typedef enum logic {RIdle, RData} rstate_e;

   wstate_e wstate_q, wstate_d;
   rstate_e rstate_q, rstate_d;

   logic                      aw_latched_q, aw_latched_d;
   logic                      w_latched_q, w_latched_d;
   logic [IdxW-1:0]           awidx_q, awidx_d;
   logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
   logic [StrbW-1:0]          wstrb_q, wstrb_d;
   logic [1:0]                bresp_q, bresp_d;
   logic [NUM_RW_REGS-1:0][31:0] regs_q, regs_d;
   logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;

   logic                      aw_hs, w_hs;
   logic [IdxW-1:0]           wr_idx;
   logic [DATA_BIT_WIDTH-1:0] wr_data;
   logic [StrbW-1:0]          wr_strb;
   logic                      wr_mapped;
   logic [IdxW-1:0]           rd_idx;
   logic [DATA_BIT_WIDTH-1:0] rd_word;
   logic [1:0]                rd_resp;

   // Byte offset bits are don't-care in the register map.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{i_awaddr[1:0], i_araddr[1:0]};

   assign o_awready = (wstate_q == WCollect) && !aw_latched_q;
   assign o_wready  = (wstate_q == WCollect) && !w_latched_q;
   assign aw_hs     = i_awvalid && o_awready;
   assign w_hs      = i_wvalid && o_wready;

   // A handshake in the current cycle takes precedence over a not-yet-latched channel,
   // so the commit can happen on the same edge as the last handshake.
   assign wr_idx    = aw_latched_q ? awidx_q : i_awaddr[ADDR_BIT_WIDTH-1:2];
   assign wr_data   = w_latched_q ? wdata_q : i_wdata;
   assign wr_strb   = w_latched_q ? wstrb_q : i_wstrb;
   assign wr_mapped = (wr_idx != '0) && (wr_idx <= IdxW'(NUM_RW_REGS));

   always_comb begin
      wstate_d     = wstate_q;
      aw_latched_d = aw_latched_q;
      w_latched_d  = w_latched_q;
      awidx_d      = awidx_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      bresp_d      = bresp_q;
      regs_d       = regs_q;
      case (wstate_q)
         WCollect: begin
            if (aw_hs) begin
               aw_latched_d = 1'b1;
               awidx_d      = i_awaddr[ADDR_BIT_WIDTH-1:2];
            end
            if (w_hs) begin
               w_latched_d = 1'b1;
               wdata_d     = i_wdata;
               wstrb_d     = i_wstrb;
            end
            if ((aw_latched_q || aw_hs) && (w_latched_q || w_hs)) begin
               wstate_d     = WResp;
               aw_latched_d = 1'b0;
               w_latched_d  = 1'b0;
               bresp_d      = wr_mapped ? RespOkay : RespSlvErr;
               for (int unsigned k = 0; k < NUM_RW_REGS; k++) begin
                  if (wr_idx == IdxW'(k + 1)) begin
                     for (int unsigned b = 0; b < StrbW; b++) begin
                        if (wr_strb[b]) begin
                           regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
                        end
                     end
                  end
               end
            end
         end
         WResp: begin
            if (i_bready) begin
               wstate_d = WCollect;
            end
         end
         default: wstate_d = WCollect;
      endcase
   end

   assign rd_idx = i_araddr[ADDR_BIT_WIDTH-1:2];

   always_comb begin
      rd_word = '0;
      rd_resp = RespSlvErr;
      if (rd_idx == '0) begin
         rd_word = ID_VALUE;
         rd_resp = RespOkay;
      end
      for (int unsigned k = 0; k < NUM_RW_REGS; k++) begin
         if (rd_idx == IdxW'(k + 1)) begin
            rd_word = regs_q[k];
            rd_resp = RespOkay;
         end
      end
   end

   // Reads sample regs_q, so a write committing on the AR edge is not yet visible.
   always_comb begin
      rstate_d = rstate_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rstate_q)
         RIdle: begin
            if (i_arvalid) begin
               rstate_d = RData;
               rdata_d  = rd_word;
               rresp_d  = rd_resp;
            end
         end
         RData: begin
            if (i_rready) begin
               rstate_d = RIdle;
            end
         end
         default: rstate_d = RIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wstate_q     <= WCollect;
         rstate_q     <= RIdle;
         aw_latched_q <= 1'b0;
         w_latched_q  <= 1'b0;
         awidx_q      <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         bresp_q      <= RespOkay;
         regs_q       <= {NUM_RW_REGS{RW_RESET_VALUE}};
         rdata_q      <= '0;
         rresp_q      <= RespOkay;
      end else begin
         wstate_q     <= wstate_d;
         rstate_q     <= rstate_d;
         aw_latched_q <= aw_latched_d;
         w_latched_q  <= w_latched_d;
         awidx_q      <= awidx_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         bresp_q      <= bresp_d;
         regs_q       <= regs_d;
         rdata_q      <= rdata_d;
         rresp_q      <= rresp_d;
      end
   end

   assign o_bvalid  = (wstate_q == WResp);
   assign o_bresp   = bresp_q;
   assign o_arready = (rstate_q == RIdle);
   assign o_rvalid  = (rstate_q == RData);
   assign o_rdata   = rdata_q;
   assign o_rresp   = rresp_q;
   assign o_rw_regs = regs_q;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Bench for axi4_lite_reg_slave: directed vector table, hand-written corner sequences and
// randomized traffic checked against an array-based model of the register map.
module tb_axi4_lite_reg_slave;

   localparam int unsigned AW   = 32;
   localparam int unsigned NREG = 4;
   localparam logic [31:0] ID   = 32'hC0DE_0001;
   localparam logic [31:0] RSTV = 32'h0000_0000;
   localparam logic [1:0]  OK   = 2'b00;
   localparam logic [1:0]  ERR  = 2'b10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   awaddr = '0;
   logic            awvalid = 1'b0;
   logic            awready;
   logic [31:0]     wdata = '0;
   logic [3:0]      wstrb = '0;
   logic            wvalid = 1'b0;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready = 1'b0;
   logic [AW-1:0]   araddr = '0;
   logic            arvalid = 1'b0;
   logic            arready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready = 1'b0;
   logic [32*NREG-1:0] rw_regs;

   axi4_lite_reg_slave #(
      .ADDR_BIT_WIDTH (AW),
      .DATA_BIT_WIDTH (32),
      .NUM_RW_REGS    (NREG),
      .ID_VALUE       (ID),
      .RW_RESET_VALUE (RSTV)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_awaddr  (awaddr),
      .i_awvalid (awvalid),
      .o_awready (awready),
      .i_wdata   (wdata),
      .i_wstrb   (wstrb),
      .i_wvalid  (wvalid),
      .o_wready  (wready),
      .o_bresp   (bresp),
      .o_bvalid  (bvalid),
      .i_bready  (bready),
      .i_araddr  (araddr),
      .i_arvalid (arvalid),
      .o_arready (arready),
      .o_rdata   (rdata),
      .o_rresp   (rresp),
      .o_rvalid  (rvalid),
      .i_rready  (rready),
      .o_rw_regs (rw_regs)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] model_regs [NREG];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NREG; k++) model_regs[k] = RSTV;
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int unsigned idx = addr >> 2;
      logic [31:0] mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      if (idx >= 1 && idx <= NREG) begin
         model_regs[idx-1] = (model_regs[idx-1] & ~mask) | (data & mask);
         return OK;
      end
      return ERR;
   endfunction

   function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                      output logic [1:0] resp);
      int unsigned idx = addr >> 2;
      if (idx == 0) begin
         data = ID; resp = OK;
      end else if (idx <= NREG) begin
         data = model_regs[idx-1]; resp = OK;
      end else begin
         data = '0; resp = ERR;
      end
   endfunction

   function automatic logic [127:0] model_packed();
      logic [127:0] p = '0;
      for (int k = 0; k < NREG; k++) p[32*k +: 32] = model_regs[k];
      return p;
   endfunction

   // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W by -gap cycles.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int gap, input int hold,
                           input logic [1:0] exp_resp);
      int aw_start = gap > 0 ? gap : 0;
      int w_start  = gap < 0 ? -gap : 0;
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int cyc = 0;
      logic [1:0] resp;
      awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid = !aw_done && cyc >= aw_start;
         wvalid  = !w_done && cyc >= w_start;
         if (w_done) check("wready_low_after_w", wready, 0);
         if (aw_done) check("awready_low_after_aw", awready, 0);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         aw_done |= aw_hs; w_done |= w_hs; cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("write_handshakes_done", aw_done && w_done, 1);
      check("bvalid_latency", bvalid, 1);
      check("bresp", bresp, exp_resp);
      resp = bresp;
      repeat (hold) begin
         @(posedge clk); #1;
         check("bvalid_hold", bvalid, 1);
         check("bresp_hold", bresp, resp);
         check("awready_wready_during_b", {awready, wready}, 2'b00);
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      check("bvalid_cleared", bvalid, 0);
      check("readies_after_b", {awready, wready}, 2'b11);
      check("rw_regs", rw_regs, model_packed());
   endtask

   task automatic do_read(input logic [31:0] addr, input int hold,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
      int cyc = 0;
      logic [31:0] d;
      logic [1:0]  r;
      araddr = addr; arvalid = 1'b1; rready = 1'b0;
      while (!arready && cyc < 40) begin
         @(posedge clk); #1; cyc++;
      end
      check("arready_seen", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      check("rvalid_latency", rvalid, 1);
      check("rdata", rdata, exp_data);
      check("rresp", rresp, exp_resp);
      d = rdata; r = rresp;
      repeat (hold) begin
         @(posedge clk); #1;
         check("rvalid_hold", rvalid, 1);
         check("rdata_hold", rdata, d);
         check("rresp_hold", rresp, r);
         check("arready_during_r", arready, 0);
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      check("rvalid_cleared", rvalid, 0);
      check("arready_after_r", arready, 1);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          gap;
      int          hold;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [17];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d, old;
      logic [3:0]  s;
      logic [1:0]  r;

      vecs[0]  = '{0, 32'h00, 32'h0, 4'h0, 0, 0, OK, ID};
      vecs[1]  = '{0, 32'h04, 32'h0, 4'h0, 0, 0, OK, 32'h0};
      vecs[2]  = '{0, 32'h08, 32'h0, 4'h0, 0, 0, OK, 32'h0};
      vecs[3]  = '{0, 32'h0C, 32'h0, 4'h0, 0, 0, OK, 32'h0};
      vecs[4]  = '{0, 32'h10, 32'h0, 4'h0, 0, 0, OK, 32'h0};
      vecs[5]  = '{1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, OK, 32'h0};
      vecs[6]  = '{0, 32'h08, 32'h0, 4'h0, 0, 0, OK, 32'hDEAD_BEEF};
      vecs[7]  = '{1, 32'h04, 32'h1122_3344, 4'b0101, 3, 0, OK, 32'h0};
      vecs[8]  = '{0, 32'h04, 32'h0, 4'h0, 0, 0, OK, 32'h0022_0044};
      vecs[9]  = '{1, 32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, ERR, 32'h0};
      vecs[10] = '{1, 32'h40, 32'hFFFF_FFFF, 4'hF, -2, 0, ERR, 32'h0};
      vecs[11] = '{0, 32'h40, 32'h0, 4'h0, 0, 5, ERR, 32'h0};
      vecs[12] = '{1, 32'h10, 32'h0000_00A5, 4'b0001, -2, 5, OK, 32'h0};
      vecs[13] = '{0, 32'h07, 32'h0, 4'h0, 0, 0, OK, 32'h0022_0044};
      vecs[14] = '{0, 32'h14, 32'h0, 4'h0, 0, 0, ERR, 32'h0};
      vecs[15] = '{0, 32'h00, 32'h0, 4'h0, 0, 2, OK, ID};
      vecs[16] = '{0, 32'h10, 32'h0, 4'h0, 0, 0, OK, 32'h0000_00A5};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_bvalid", bvalid, 0);
      check("reset_rvalid", rvalid, 0);
      check("reset_bresp", bresp, 0);
      check("reset_rresp", rresp, 0);
      check("reset_rdata", rdata, 0);
      check("reset_readies", {awready, wready, arready}, 3'b111);
      check("reset_rw_regs", rw_regs, model_packed());
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_readies", {awready, wready, arready}, 3'b111);

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr) begin
            void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].gap, vecs[i].hold,
                     vecs[i].resp);
         end else begin
            do_read(vecs[i].addr, vecs[i].hold, vecs[i].rdata, vecs[i].resp);
         end
      end

      // AR handshake on the same edge as a write commit returns the old value.
      model_read(32'h0C, old, r);
      awaddr = 32'h0C; wdata = 32'h5A5A_1234; wstrb = 4'hF; araddr = 32'h0C;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      void'(model_write(32'h0C, 32'h5A5A_1234, 4'hF));
      check("collision_bvalid", bvalid, 1);
      check("collision_rvalid", rvalid, 1);
      check("collision_rdata_old", rdata, old);
      check("collision_rw_regs", rw_regs, model_packed());
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
      do_read(32'h0C, 0, 32'h5A5A_1234, OK);

      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            r = model_write(a, d, s);
            do_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), r);
         end else begin
            model_read(a, d, r);
            do_read(a, int'($urandom_range(0, 3)), d, r);
         end
      end

      // Reset while a B response is pending abandons it.
      awaddr = 32'h04; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      void'(model_write(32'h04, 32'hFFFF_FFFF, 4'hF));
      check("pre_reset_bvalid", bvalid, 1);
      check("pre_reset_rw_regs", rw_regs, model_packed());
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("async_reset_bvalid", bvalid, 0);
      check("async_reset_rw_regs", rw_regs, model_packed());
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("reset_release_readies", {awready, wready, arready}, 3'b111);
      repeat (3) @(posedge clk);
      #1;
      check("no_b_after_reset", bvalid, 0);
      check("no_r_after_reset", rvalid, 0);
      do_read(32'h04, 0, RSTV, OK);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
